truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Controller that sequences a 3-input combinational function block (A,B,C -> F) through all 8 input vectors. It waits a programmable settle time per vector, samples F, and assembles the 8-bit truth table. At the end it compares the table against an expected table and reports a mismatch. It sits between a start/status interface and the function block, and is the sole driver of the block's A/B/C inputs.

Parameters:
SETTLE_CYCLES, 2, cycles abc_out is held stable before F is sampled; legal range 1..15.
CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
abort  input  1  synchronous abort of a running sweep
expected  input  8  expected truth table; bit i = F for {A,B,C}=i; sampled on accepted start
f_in  input  1  F output of the function block
abc_out  output  3  drives {A,B,C} of the function block; A is the MSB
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
aborted  output  1  one-cycle pulse when a sweep is aborted
table_out  output  8  captured truth table
mismatch  output  1  table_out != expected latch; valid from done
mismatch_mask  output  8  table_out XOR expected latch

Behaviour:
- Reset (async, rst=1): state IDLE; abc_out=0, busy=0, done=0, aborted=0, table_out=0, mismatch=0, mismatch_mask=0; idx=0, cnt=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: start=1 at edge k accepts the request.
  - expected is latched and table_out is cleared.
  - idx=0, abc_out=0, cnt=0.
  - Next state SETTLE; busy=1 from cycle k+1.
- SETTLE: cnt increments each cycle; abc_out=idx is held. When cnt==SETTLE_CYCLES-1, next state is SAMPLE.
- SAMPLE: table_out[idx] <= f_in.
  - If idx==7, next state is FINISH.
  - Otherwise idx increments, abc_out follows, cnt=0, and the next state is SETTLE.
- FINISH: one cycle. done=1, busy=0, mismatch and mismatch_mask are updated from the final table; next state is IDLE.
- Latency: SETTLE_CYCLES+1 cycles per vector. For a start accepted at edge k, done is high in cycle k+1+8*(SETTLE_CYCLES+1); default SETTLE_CYCLES=2 gives k+25.
- table_out, mismatch and mismatch_mask hold their values until the next accepted start or a reset.
- start while busy is ignored, with no effect on idx, cnt or the latched expected.
- start in the FINISH cycle is ignored; a new start is accepted only in IDLE.
- abort in SETTLE or SAMPLE: next state IDLE.
  - aborted pulses one cycle; busy=0; abc_out=0.
  - table_out keeps its partial contents; mismatch is not updated; done does not fire.
- abort in IDLE or FINISH is ignored.
- abort and start in the same IDLE cycle: start wins.
- abort has priority over the SAMPLE capture; the bit is not written.
- Reset mid-sweep: immediate return to the reset values; no done or aborted pulse.
- Outputs are registered; abc_out changes only on clk edges.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_FINISH;
  - NUM_VECTORS=8;
  - GOLDEN_TABLE=8'h45, the reference function's truth table: F=1 for ABC=000, 010, 110.
- One natural sub-module, sweep_settle_timer: a counter with clear/enable inputs and a terminal flag at SETTLE_CYCLES-1, reused by other sequencers.
- The bench instantiates the existing 3-input function block and connects abc_out to it and its F output to f_in.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0 and abc_out=0 for 20 cycles.
- Golden sweep: start=1 at edge k with expected=8'h45, real function block attached.
  - abc_out steps 0..7, each value held for 3 cycles.
  - done pulses at k+25 with table_out=8'h45, mismatch=0, mismatch_mask=0.
- Mismatch: expected=8'h44 -> done, table_out=8'h45, mismatch=1, mismatch_mask=8'h01.
- Busy start ignored: second start while idx=3 -> a single done at k+25, table unchanged, no restart.
- Abort: abort asserted in the SAMPLE cycle of idx=4.
  - aborted pulses and no done occurs.
  - table_out[4] is not written; table_out[3:0]=4'h5, table_out[7:4]=0.
  - busy=0 next cycle.
- Async reset mid-sweep: rst between edges at idx=5.
  - Outputs clear immediately without waiting for clk.
  - A start afterwards produces a complete sweep with table_out=8'h45.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its bench.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_e;

    localparam int unsigned NUM_VECTORS  = 8;
    localparam logic [2:0]  LAST_IDX     = 3'(NUM_VECTORS - 1);
    // Truth table of the reference function: F=1 for ABC = 000, 010, 110.
    localparam logic [7:0]  GOLDEN_TABLE = 8'h45;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Start/status interface between a host and the truth-table sweeper.
interface truth_table_sweeper_if;

    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] table_out;
    logic       mismatch;
    logic [7:0] mismatch_mask;

    modport master (
        output start, abort, expected,
        input  busy, done, aborted, table_out, mismatch, mismatch_mask
    );

    modport slave (
        input  start, abort, expected,
        output busy, done, aborted, table_out, mismatch, mismatch_mask
    );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter with clear/enable; term flags a count of SETTLE_CYCLES-1.
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input function block through all input vectors and captures its truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus,
    input  logic                  f_in,
    output logic [2:0]            abc_out
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] table_q, table_d;
    logic [7:0] mask_q, mask_d;
    logic       mismatch_q, mismatch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       aborted_q, aborted_d;
    logic       cnt_clr, cnt_en, cnt_term;

    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (cnt_term)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        abc_d      = abc_q;
        exp_d      = exp_q;
        table_d    = table_q;
        mask_d     = mask_q;
        mismatch_d = mismatch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.expected;
                    table_d = '0;
                    idx_d   = '0;
                    abc_d   = '0;
                    cnt_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                    abc_d     = '0;
                    cnt_clr   = 1'b1;
                end else if (state_q == ST_SETTLE) begin
                    cnt_en = 1'b1;
                    if (cnt_term) state_d = ST_SAMPLE;
                end else begin
                    table_d[idx_q] = f_in;
                    if (idx_q == LAST_IDX) begin
                        // Compare using the table including the bit captured this edge,
                        // so mismatch is valid in the same cycle as done.
                        state_d    = ST_FINISH;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        mask_d     = table_d ^ exp_q;
                        mismatch_d = |(table_d ^ exp_q);
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        abc_d   = idx_q + 3'd1;
                        cnt_clr = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            abc_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            abc_q      <= abc_d;
            exp_q      <= exp_d;
            table_q    <= table_d;
            mask_q     <= mask_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign abc_out           = abc_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.table_out     = table_q;
    assign bus.mismatch      = mismatch_q;
    assign bus.mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with the reference function block modelled inline.
module tb_truth_table_sweeper;
    import truth_table_sweeper_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] abc_out;
    logic       f_in;
    logic [7:0] golden = GOLDEN_TABLE;

    int total = 0;
    int bad   = 0;

    truth_table_sweeper_if bus ();

    truth_table_sweeper #(
        .SETTLE_CYCLES (2),
        .CNT_W         (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .f_in    (f_in),
        .abc_out (abc_out)
    );

    // Reference 3-input function block.
    assign f_in = golden[abc_out];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h00, abc_out, bus.busy, bus.done, bus.aborted, bus.table_out,
                bus.mismatch, bus.mismatch_mask} & 32'h00ffffff;
    endfunction

    // Starts a sweep, then observes 40 cycles. sj/aj/rj: cycle index at which
    // to raise start / abort / async reset (-1 = never). j counts edges after the start edge.
    task automatic sweep(input logic [7:0] exp, input int sj, input int aj, input int rj,
                         input bit chk_abc, output int n_done, output int done_j,
                         output int n_ab, output int ab_j);
        n_done = 0; done_j = -1; n_ab = 0; ab_j = -1;
        bus.expected = exp;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        if (chk_abc) chk("abc_first", {29'd0, abc_out}, 32'd0);
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if (bus.done) begin n_done++; done_j = j; end
            if (bus.aborted) begin
                n_ab++; ab_j = j;
                chk("abort_busy", {31'd0, bus.busy}, 32'd0);
                chk("abort_abc", {29'd0, abc_out}, 32'd0);
            end
            if (chk_abc && j < 24) chk("abc_step", {29'd0, abc_out}, 32'(j / 3));
            if (chk_abc && j == 24) chk("finish_busy", {31'd0, bus.busy}, 32'd0);
            bus.start = (j == sj);
            bus.abort = (j == aj);
            if (j == rj) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_async_clear", all_outs(), 32'd0);
                rst = 1'b0;
                bus.start = 1'b0;
                bus.abort = 1'b0;
                return;
            end
        end
    endtask

    int nd, dj, na, aj;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.expected = '0;
        #12 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", all_outs(), 32'd0);
        end

        // Golden sweep
        sweep(8'h45, -1, -1, -1, 1'b1, nd, dj, na, aj);
        chk("gold_ndone", nd, 1);
        chk("gold_done_cycle", dj, 24);
        chk("gold_naborted", na, 0);
        chk("gold_table", bus.table_out, 8'h45);
        chk("gold_mismatch", bus.mismatch, 0);
        chk("gold_mask", bus.mismatch_mask, 0);

        // Start while busy at idx 3 must be ignored
        sweep(8'h45, 10, -1, -1, 1'b0, nd, dj, na, aj);
        chk("busy_start_ndone", nd, 1);
        chk("busy_start_done_cycle", dj, 24);
        chk("busy_start_table", bus.table_out, 8'h45);
        chk("busy_start_mismatch", bus.mismatch, 0);

        // Mismatch
        sweep(8'h44, -1, -1, -1, 1'b0, nd, dj, na, aj);
        chk("mm_ndone", nd, 1);
        chk("mm_done_cycle", dj, 24);
        chk("mm_table", bus.table_out, 8'h45);
        chk("mm_mismatch", bus.mismatch, 1);
        chk("mm_mask", bus.mismatch_mask, 8'h01);

        // Abort in the SAMPLE cycle of idx 4
        sweep(8'h45, -1, 14, -1, 1'b0, nd, dj, na, aj);
        chk("abort_ndone", nd, 0);
        chk("abort_naborted", na, 1);
        chk("abort_cycle", aj, 15);
        chk("abort_table", bus.table_out, 8'h05);
        chk("abort_busy_after", bus.busy, 0);
        chk("abort_mismatch_held", bus.mismatch, 1);
        chk("abort_mask_held", bus.mismatch_mask, 8'h01);

        // Async reset during idx 5, then a full sweep
        sweep(8'h45, -1, -1, 16, 1'b0, nd, dj, na, aj);
        chk("rst_ndone", nd, 0);
        chk("rst_naborted", na, 0);
        @(negedge clk);
        chk("rst_idle_after", all_outs(), 32'd0);
        sweep(8'h45, -1, -1, -1, 1'b1, nd, dj, na, aj);
        chk("post_rst_ndone", nd, 1);
        chk("post_rst_done_cycle", dj, 24);
        chk("post_rst_table", bus.table_out, 8'h45);
        chk("post_rst_mismatch", bus.mismatch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
